alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters, e.g. the EX-stage datapath and a multi-cycle helper. It gives each requester a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. Operands are registered before they reach the ALU, so ALU inputs stay stable for a full cycle, and the result is held in a register until the owner accepts it.

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters using
// round-robin arbitration. Each requester has a valid/ready request channel
// (operands + opcode) and a valid/ready response channel (result + zero).
// One operation is in flight at a time: IDLE (grant) -> ISSUE (operands held
// in registers drive the ALU) -> RESP (registered result held until taken).
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   req{0,1}_valid/ready      request handshake
//   req{0,1}_a/_b/_op         request operands and opcode
//   rsp{0,1}_valid/ready      response handshake
//   rsp{0,1}_c/_zero          captured result and zero flag
//   alu_a/alu_b/alu_op        registered operands to the shared ALU
//   alu_c/alu_zero            result from the shared ALU
//   busy                      high whenever an operation is in progress
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [OPW-1:0]   opop_reg, opop_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic [WIDTH-1:0] res_c_reg, res_c_next;
    logic             res_z_reg, res_z_next;

    logic [1:0] req_valid_vec;
    logic [1:0] grant_vec;
    logic [1:0] req_ready_vec;
    logic [1:0] rsp_valid_vec;
    logic [1:0] rsp_ready_vec;
    logic       req_fire;
    logic       req_sel;

    assign req_valid_vec = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    // A lone requester always wins; on a tie the one not served last wins.
    // Outputs are forced low while reset_n is low so they are defined even
    // before the first reset edge has cleared the state register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            assign grant_vec[gi] = req_valid_vec[gi] &
                                   (~req_valid_vec[1-gi] | (last_reg != 1'(gi)));
            assign req_ready_vec[gi] = reset_n & (state_reg == IDLE) & grant_vec[gi];
            assign rsp_valid_vec[gi] = reset_n & (state_reg == RESP) &
                                       (owner_reg == 1'(gi));
        end
    endgenerate

    // At most one ready is high, so the requester with ready set is the one
    // being loaded.
    assign req_fire = |(req_valid_vec & req_ready_vec);
    assign req_sel  = req_ready_vec[1];

    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        opop_next  = opop_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        res_c_next = res_c_reg;
        res_z_next = res_z_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    opa_next   = req_sel ? req1_a  : req0_a;
                    opb_next   = req_sel ? req1_b  : req0_b;
                    opop_next  = req_sel ? req1_op : req0_op;
                    owner_next = req_sel;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                res_c_next = alu_c;
                res_z_next = alu_zero;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_vec[owner_reg]) begin
                    last_next  = owner_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            opop_reg  <= '0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            res_c_reg <= '0;
            res_z_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            opop_reg  <= opop_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            res_c_reg <= res_c_next;
            res_z_reg <= res_z_next;
        end
    end

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_c     = reset_n ? res_c_reg : '0;
    assign rsp1_c     = reset_n ? res_c_reg : '0;
    assign rsp0_zero  = reset_n & res_z_reg;
    assign rsp1_zero  = reset_n & res_z_reg;
    assign alu_a      = reset_n ? opa_reg  : '0;
    assign alu_b      = reset_n ? opb_reg  : '0;
    assign alu_op     = reset_n ? opop_reg : '0;
    assign busy       = reset_n & (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the shared ALU, drives directed
// requests, and checks responses through an expected-result queue that a
// separate monitor process drains whenever a response handshake occurs.
module tb_alu_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_c, rsp1_c;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_op;
    logic        alu_zero;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] c;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];

    alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_c(rsp0_c), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_c(rsp1_c), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model
    always_comb begin
        case (alu_op)
            5'd0:    alu_c = alu_a & alu_b;
            5'd1:    alu_c = alu_a | alu_b;
            5'd2,
            5'd3:    alu_c = alu_a + alu_b;
            5'd4:    alu_c = alu_a & ~alu_b;
            5'd5:    alu_c = alu_a | ~alu_b;
            5'd6:    alu_c = alu_a - alu_b;
            5'd7:    alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
            5'd8:    alu_c = {31'd0, alu_a < alu_b};
            5'd9:    alu_c = alu_b;
            default: alu_c = 32'd0;
        endcase
        alu_zero = (alu_c == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] c, input logic z);
        exp_t e;
        e.id = id;
        e.c  = c;
        e.z  = z;
        sb.push_back(e);
    endtask

    // Monitor: compares every response handshake against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp0_valid && rsp1_valid)
                check("both_rsp_valid", 32'd1, 32'd0);
            if (rsp0_valid && rsp0_ready) begin
                if (sb.size() == 0) check("unexpected_rsp0", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    $display("rsp0 c=%h zero=%0d (expected id %0d c=%h zero=%0d)",
                             rsp0_c, rsp0_zero, e.id, e.c, e.z);
                    check("rsp0_id", 32'd0, 32'(e.id));
                    check("rsp0_c", rsp0_c, e.c);
                    check("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, e.z});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (sb.size() == 0) check("unexpected_rsp1", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    $display("rsp1 c=%h zero=%0d (expected id %0d c=%h zero=%0d)",
                             rsp1_c, rsp1_zero, e.id, e.c, e.z);
                    check("rsp1_id", 32'd1, 32'(e.id));
                    check("rsp1_c", rsp1_c, e.c);
                    check("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, e.z});
                end
            end
        end
    end

    // Holds a request on channel ch until it is accepted (bounded wait).
    task automatic drive(input int ch, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [31:0] expc, input logic expz);
        bit got = 1'b0;
        @(negedge clk);
        if (ch == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        for (int k = 0; k < 30; k++) begin
            #1;
            if ((ch == 0 && req0_ready) || (ch == 1 && req1_ready)) begin
                got = 1'b1;
                $display("grant req%0d a=%h b=%h op=%0d", ch, a, b, op);
                grant_log.push_back(ch);
                push_exp(ch, expc, expz);
                break;
            end
            @(negedge clk);
        end
        if (!got) check("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        reset_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_op = 5'd2;
        req1_valid = 1'b1; req1_a = 32'h33; req1_b = 32'h44; req1_op = 5'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset with both requests valid
        repeat (2) begin
            @(negedge clk); #1;
            check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
            check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
            check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
            check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_alu_a", alu_a, 32'd0);
            check("rst_rsp0_c", rsp0_c, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        // Single request: 5 + 7
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 5'd2;
        #1;
        check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
        push_exp(0, 32'd12, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_b", alu_b, 32'd7);
        check("single_alu_op", {27'd0, alu_op}, 32'd2);
        check("single_busy", {31'd0, busy}, 32'd1);
        check("single_issue_ready", {31'd0, req0_ready}, 32'd0);
        @(negedge clk); #1;
        check("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        @(negedge clk); #1;
        check("single_idle_busy", {31'd0, busy}, 32'd0);

        // Tie after reset: req0 wins first
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 5'd6;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 5'd7;
        #1;
        check("tie_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("tie_req1_ready", {31'd0, req1_ready}, 32'd0);
        push_exp(0, 32'd0, 1'b1);
        @(negedge clk); req0_valid = 1'b0; #1;
        check("tie_issue_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk); #1;
        check("tie_resp_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk); #1;
        check("tie_req1_granted", {31'd0, req1_ready}, 32'd1);
        push_exp(1, 32'd1, 1'b0);
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("tie_idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure on rsp0 with req1 waiting
        @(negedge clk);
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00; req0_op = 5'd0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 5'd3;
        #1;
        check("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
        push_exp(0, 32'h0000_F000, 1'b0);
        @(negedge clk); req0_valid = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            check("bp_rsp0_c", rsp0_c, 32'h0000_F000);
            check("bp_busy", {31'd0, busy}, 32'd1);
            check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        @(negedge clk); rsp0_ready = 1'b1; #1;
        check("bp_release_valid", {31'd0, rsp0_valid}, 32'd1);
        @(negedge clk); #1;
        check("bp_req1_granted", {31'd0, req1_ready}, 32'd1);
        push_exp(1, 32'd2, 1'b0);
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("bp_idle_busy", {31'd0, busy}, 32'd0);

        // Reset during ISSUE discards the operation
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'h0000_ABCD; req1_op = 5'd9;
        #1;
        check("rmid_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0; reset_n = 1'b0;
        #1;
        check("rmid_busy_in_reset", {31'd0, busy}, 32'd0);
        check("rmid_alu_b_in_reset", alu_b, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            check("rmid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
            check("rmid_busy", {31'd0, busy}, 32'd0);
        end

        // Round-robin: both requesters hold valid for four operations
        fork
            begin
                drive(0, 32'h0000_000F, 32'h0000_00F0, 5'd1, 32'h0000_00FF, 1'b0);
                drive(0, 32'h0000_00FF, 32'h0000_000F, 5'd4, 32'h0000_00F0, 1'b0);
                @(negedge clk); req0_valid = 1'b0;
            end
            begin
                drive(1, 32'd0, 32'hFFFF_FFFF, 5'd5, 32'd0, 1'b1);
                drive(1, 32'd1, 32'hFFFF_FFFF, 5'd8, 32'd1, 1'b0);
                @(negedge clk); req1_valid = 1'b0;
            end
        join
        repeat (8) @(negedge clk);

        check("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        check("pending_responses", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
